// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready flow control, flush and bubble-clean controls.
// Define EX_MEM_SKID_EN to add a skid slot behind the main register (registered in_ready).
module ex_mem_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     st;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  mr;
        logic                  mw;
    } payload_t;

    payload_t in_p;
    payload_t m_q, m_d;
    logic     m_valid_q, m_valid_d;
    logic     in_fire, out_fire;

    assign in_p = {in_alu_result, in_store_data, in_rd,
                   in_reg_write, in_mem_read, in_mem_write};

    assign in_fire  = in_valid && in_ready;
    assign out_fire = m_valid_q && out_ready;

`ifdef EX_MEM_SKID_EN
    payload_t s_q, s_d;
    logic     s_valid_q, s_valid_d;

    assign in_ready  = !s_valid_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    // Skid entry refills M before any new input may be accepted.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (out_fire && s_valid_q) begin
            m_d       = s_q;
            s_valid_d = 1'b0;
        end else if (in_fire && (!m_valid_q || out_fire)) begin
            m_d       = in_p;
            m_valid_d = 1'b1;
        end else if (in_fire) begin
            s_d       = in_p;
            s_valid_d = 1'b1;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q       <= '0;
            s_valid_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
        end
    end
`else
    assign in_ready  = !m_valid_q || out_ready;
    assign occupancy = {1'b0, m_valid_q};

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (in_fire) begin
            m_d       = in_p;
            m_valid_d = 1'b1;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Control bits are gated so an invalid slot never looks like a live op.
    assign out_valid      = m_valid_q;
    assign out_alu_result = m_q.alu;
    assign out_store_data = m_q.st;
    assign out_rd         = m_q.rd;
    assign out_reg_write  = m_q.rw && m_valid_q;
    assign out_mem_read   = m_q.mr && m_valid_q;
    assign out_mem_write  = m_q.mw && m_valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, streaming, stall, flush,
// bubble-clean and a 32-bit / 5-bit-index instance.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_alu, in_st, out_alu, out_st;
    logic [3:0]  in_rd, out_rd;
    logic        in_rw, in_mr, in_mw, out_rw, out_mr, out_mw;
    logic [1:0]  occ;

    logic        w_in_valid, w_in_ready, w_out_valid;
    logic [31:0] w_in_alu, w_out_alu, w_out_st;
    logic [4:0]  w_in_rd, w_out_rd;
    logic        w_out_rw, w_out_mr, w_out_mw;
    logic [1:0]  w_occ;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu), .in_store_data(in_st), .in_rd(in_rd),
        .in_reg_write(in_rw), .in_mem_read(in_mr), .in_mem_write(in_mw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu), .out_store_data(out_st), .out_rd(out_rd),
        .out_reg_write(out_rw), .out_mem_read(out_mr), .out_mem_write(out_mw),
        .occupancy(occ)
    );

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut_w (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_alu_result(w_in_alu), .in_store_data(32'h0), .in_rd(w_in_rd),
        .in_reg_write(1'b1), .in_mem_read(1'b0), .in_mem_write(1'b0),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_alu_result(w_out_alu), .out_store_data(w_out_st), .out_rd(w_out_rd),
        .out_reg_write(w_out_rw), .out_mem_read(w_out_mr), .out_mem_write(w_out_mw),
        .occupancy(w_occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_alu = 16'hBEEF; in_st = 16'h1234; in_rd = 4'd5;
        in_rw = 1'b1; in_mr = 1'b1; in_mw = 1'b1; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_alu = '0; w_in_rd = '0;

        // reset
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_alu", out_alu, 0);
        chk("rst_st", out_st, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_ctl", {out_rw, out_mr, out_mw}, 0);
        chk("rst_occ", occ, 0);
        reset = 1'b0; in_valid = 1'b0;
        in_rw = 1'b0; in_mr = 1'b0; in_mw = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // streaming
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_alu   = 16'(i);
            in_st    = 16'(i + 256);
            in_rd    = 4'(i);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_alu", out_alu, 64'(i));
            chk("stream_rd", out_rd, 64'(i % 16));
            chk("stream_occ", occ, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", out_valid, 0);

        // stall
        out_ready = 1'b0;
        in_valid  = 1'b1; in_alu = 16'h1111;
        tick();
        chk("stall_m_alu", out_alu, 16'h1111);
        chk("stall_m_occ", occ, 1);
        in_alu = 16'h2222;
        #1;
`ifdef EX_MEM_SKID_EN
        chk("stall_skid_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("stall_skid_occ", occ, 2);
        chk("stall_skid_nrdy", in_ready, 0);
        tick();
        chk("stall_hold_alu", out_alu, 16'h1111);
        out_ready = 1'b1;
        tick();
        chk("stall_second", out_alu, 16'h2222);
        chk("stall_second_v", out_valid, 1);
        chk("stall_second_occ", occ, 1);
`else
        chk("stall_nrdy", in_ready, 0);
        tick();
        chk("stall_hold_alu", out_alu, 16'h1111);
        chk("stall_hold_occ", occ, 1);
        tick();
        chk("stall_hold_alu2", out_alu, 16'h1111);
        out_ready = 1'b1;
        #1;
        chk("stall_rel_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall_second", out_alu, 16'h2222);
        chk("stall_second_v", out_valid, 1);
`endif
        tick();
        chk("stall_empty", out_valid, 0);

        // flush
        out_ready = 1'b0;
        in_valid  = 1'b1; in_alu = 16'h4444;
        tick();
`ifdef EX_MEM_SKID_EN
        in_alu = 16'h5555;
        tick();
        chk("flush_pre_occ", occ, 2);
`else
        chk("flush_pre_occ", occ, 1);
`endif
        flush = 1'b1; out_ready = 1'b1; in_alu = 16'h3333;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_occ", occ, 0);
        tick();
        chk("flush_no3333", out_valid, 0);

        // bubble-clean
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 16'h7777; in_st = 16'hABCD;
        in_rw = 1'b1; in_mw = 1'b1; in_mr = 1'b0;
        tick();
        chk("bub_mw_live", out_mw, 1);
        chk("bub_rw_live", out_rw, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bub_valid", out_valid, 0);
        chk("bub_mw", out_mw, 0);
        chk("bub_rw", out_rw, 0);
        chk("bub_st_hold", out_st, 16'hABCD);
        in_rw = 1'b0; in_mw = 1'b0;

        // width sweep
        w_in_valid = 1'b1; w_in_alu = 32'hDEADBEEF; w_in_rd = 5'd31;
        tick();
        w_in_valid = 1'b0;
        chk("w_valid", w_out_valid, 1);
        chk("w_alu", w_out_alu, 32'hDEADBEEF);
        chk("w_rd", w_out_rd, 31);
        chk("w_rw", w_out_rw, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX→MEM pipeline stage register with valid/ready flow control, flush and bubble-clean control outputs. It sits between the ALU/execute stage and the data-memory stage and carries the ALU result, store data, destination register and memory/write-back controls. It adds stall back-pressure, flush and an optional skid slot for full throughput with a registered `in_ready`.

## Interface
Parameters:
- `DATA_W`, default 16: width of ALU result and store data.
- `REG_ADDR_W`, default 4: width of the destination register index.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: discard all held entries (branch mispredict / exception).
- `in_valid` in 1: EX stage presents a valid instruction.
- `in_ready` out 1: stage accepts the input this cycle.
- `in_alu_result` in DATA_W: ALU result / memory address.
- `in_store_data` in DATA_W: rs2 data for stores.
- `in_rd` in REG_ADDR_W: destination register.
- `in_reg_write`, `in_mem_read`, `in_mem_write` in 1 each: control bits.
- `out_valid` out 1: MEM stage payload valid.
- `out_ready` in 1: MEM stage consumes the payload this cycle.
- `out_alu_result`, `out_store_data` out DATA_W: held payload.
- `out_rd` out REG_ADDR_W: held destination.
- `out_reg_write`, `out_mem_read`, `out_mem_write` out 1 each: control bits, bubble-clean.
- `occupancy` out 2: number of held entries (0–1 without skid, 0–2 with).

## Operation
- Input handshake fires when `in_valid && in_ready`; output handshake fires when `out_valid && out_ready`.
- Main register (M) drives the outputs. The optional skid register (S) sits behind M.
- Without skid:
  - `in_ready = !M.valid || out_ready` (combinational path from `out_ready`).
  - On input fire, the payload loads into M.
  - On output fire with no input fire, `M.valid` clears.
- With skid:
  - `in_ready = !S.valid` (registered).
  - Input fire with M empty, or with M draining this cycle and S empty: load M.
  - Input fire with M held (`out_ready=0`): load S.
  - Output fire with S valid: S moves to M, S clears. A simultaneous input fire is impossible in this case because `in_ready=0`.
- Bubble-clean outputs:
  - `out_reg_write`, `out_mem_read`, `out_mem_write` are the stored bits ANDed with `out_valid`, so they are 0 whenever `out_valid=0`.
  - Payload data fields hold their last value while invalid.
- Flush:
  - Next cycle, all valid bits are 0 and `occupancy` is 0.
  - Any input fire in the flush cycle is discarded.
  - Flush has priority over every handshake.
  - `in_ready` is unaffected during the flush cycle itself.
- Reset:
  - All valid bits are 0.
  - All payload registers are 0; every output reads 0.
  - `in_ready` reads 1 after the reset cycle.
  - Reset overrides flush and in-flight handshakes.
- Both handshakes in the same cycle with one entry held: throughput is 1/cycle and `occupancy` is unchanged.
- Handshake values are unconstrained when `in_valid` is deasserted; the stage must not latch on `!in_valid`.

## Timing
- Latency: 1 cycle from input fire to `out_valid` (M path).
- Skid path: the entry appears on the outputs the cycle after M drains.
- Throughput: 1 instruction/cycle sustained with `out_ready=1`.
- Stall response:
  - Without skid: `in_ready` drops in the same cycle `out_ready` drops, if M is valid.
  - With skid: `in_ready` drops one cycle after the stall begins, once S fills.
- `occupancy` is registered and updates on the edge following each event.

## Configuration
- Macro `EX_MEM_SKID_EN`.
- Defined: skid register S is present, `in_ready` is a pure flop output, and `occupancy` ranges 0–2.
- Undefined: there is no S; `in_ready` is combinational from `out_ready` and M valid, and `occupancy` ranges 0–1 (bit 1 tied 0).
- Interface is identical in both builds.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid=1` and `in_alu_result=0xBEEF` → all outputs 0 and `occupancy=0`; `in_ready=1` on the first cycle after release.
- **Streaming:** `out_ready=1`, push ALU results 0x0001..0x0010 back-to-back with `in_rd` 1..16 (truncated to REG_ADDR_W) → each appears exactly 1 cycle later, in order, with no gaps.
- **Stall:**
  - Push 0x1111 then 0x2222, and hold `out_ready=0` for 3 cycles.
  - Skid build: `occupancy=2`, `in_ready=0` after the second push, and `out_alu_result` stays 0x1111.
  - Non-skid build: 0x2222 is not accepted until 0x1111 drains.
  - Release `out_ready` → 0x1111 then 0x2222 on consecutive cycles.
- **Flush:** with two entries held (skid build) or one entry (non-skid), assert `flush` while pushing 0x3333 → next cycle `out_valid=0` and `occupancy=0`; 0x3333 never appears.
- **Bubble-clean:**
  - Load an entry with `mem_write=1` and `reg_write=1`, then let it drain with `in_valid=0`.
  - `out_mem_write` and `out_reg_write` are 0 whenever `out_valid=0`.
  - `out_store_data` retains its last value.
- **Width sweep:** instantiate with `DATA_W=32` and `REG_ADDR_W=5`; push 0xDEADBEEF to rd 31 → the outputs match exactly after 1 cycle.
